// File: rtl/alu_reservation_station_if.sv
// Bundles the dispatch bus, CDB broadcast, flush and issue port of the ALU reservation station.
// RS_CDB_DUAL_EN adds the second CDB (cdb1_*).
interface alu_reservation_station_if #(
  parameter int PHY_W = 8,
  parameter int IDX_W = 3
);
  logic             add_rs_on;
  logic [31:0]      in_operand1;
  logic [31:0]      in_operand2;
  logic [PHY_W-1:0] in_Operand1_phy;
  logic [PHY_W-1:0] in_Operand2_phy;
  logic [1:0]       in_valid;
  logic [PHY_W-1:0] in_rd_phy_reg;
  logic [2:0]       in_func3;
  logic [31:0]      in_pc;
  logic [31:0]      in_immediate;
  logic [31:0]      in_inst_num;
  logic [8:0]       in_ctrl;
  logic             cdb_valid;
  logic [PHY_W-1:0] cdb_phy;
  logic [31:0]      cdb_value;
`ifdef RS_CDB_DUAL_EN
  logic             cdb1_valid;
  logic [PHY_W-1:0] cdb1_phy;
  logic [31:0]      cdb1_value;
`endif
  logic             flush;
  logic [31:0]      flush_inst_num;
  logic             rs_full;
  logic [IDX_W:0]   rs_count;
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_operand1;
  logic [31:0]      issue_operand2;
  logic [PHY_W-1:0] issue_rd_phy_reg;
  logic [2:0]       issue_func3;
  logic [31:0]      issue_pc;
  logic [31:0]      issue_immediate;
  logic [31:0]      issue_inst_num;
  logic [8:0]       issue_ctrl;

  modport slave (
`ifdef RS_CDB_DUAL_EN
    input  cdb1_valid, cdb1_phy, cdb1_value,
`endif
    input  add_rs_on, in_operand1, in_operand2, in_Operand1_phy, in_Operand2_phy, in_valid,
           in_rd_phy_reg, in_func3, in_pc, in_immediate, in_inst_num, in_ctrl,
           cdb_valid, cdb_phy, cdb_value, flush, flush_inst_num, issue_ready,
    output rs_full, rs_count, issue_valid, issue_operand1, issue_operand2, issue_rd_phy_reg,
           issue_func3, issue_pc, issue_immediate, issue_inst_num, issue_ctrl
  );

  modport master (
`ifdef RS_CDB_DUAL_EN
    output cdb1_valid, cdb1_phy, cdb1_value,
`endif
    output add_rs_on, in_operand1, in_operand2, in_Operand1_phy, in_Operand2_phy, in_valid,
           in_rd_phy_reg, in_func3, in_pc, in_immediate, in_inst_num, in_ctrl,
           cdb_valid, cdb_phy, cdb_value, flush, flush_inst_num, issue_ready,
    input  rs_full, rs_count, issue_valid, issue_operand1, issue_operand2, issue_rd_phy_reg,
           issue_func3, issue_pc, issue_immediate, issue_inst_num, issue_ctrl
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU-path reservation station: buffers micro-ops, wakes operands from the CDB and issues the
// oldest ready entry through a registered valid/ready port. RS_CDB_DUAL_EN enables a second CDB.
module alu_reservation_station #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int PHY_W = 8
) (
  input logic                      clk,
  input logic                      reset,
  alu_reservation_station_if.slave rs
);
  typedef struct packed {
    logic [31:0]      operand1;
    logic [31:0]      operand2;
    logic [PHY_W-1:0] rd;
    logic [2:0]       func3;
    logic [31:0]      pc;
    logic [31:0]      immediate;
    logic [31:0]      inst_num;
    logic [8:0]       ctrl;
  } payload_t;

  typedef struct packed {
    payload_t         p;
    logic [PHY_W-1:0] tag1;
    logic [PHY_W-1:0] tag2;
    logic             rdy1;
    logic             rdy2;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  payload_t         iss_q;
  logic             iss_vld_q;
  logic [IDX_W:0]   cnt_q;

  logic             c1_valid;
  logic [PHY_W-1:0] c1_phy;
  logic [31:0]      c1_value;
`ifdef RS_CDB_DUAL_EN
  assign c1_valid = rs.cdb1_valid;
  assign c1_phy   = rs.cdb1_phy;
  assign c1_value = rs.cdb1_value;
`else
  assign c1_valid = 1'b0;
  assign c1_phy   = '0;
  assign c1_value = '0;
`endif

  // {hit, value}; the second bus is checked last so it wins a double match
  function automatic logic [32:0] cdb_match(
    input logic [PHY_W-1:0] tag,
    input logic v0, input logic [PHY_W-1:0] p0, input logic [31:0] x0,
    input logic v1, input logic [PHY_W-1:0] p1, input logic [31:0] x1
  );
    logic [32:0] r;
    r = '0;
    if (v0 && p0 == tag) r = {1'b1, x0};
    if (v1 && p1 == tag) r = {1'b1, x1};
    return r;
  endfunction

  logic [32:0]    wk1 [DEPTH];
  logic [32:0]    wk2 [DEPTH];
  logic [32:0]    bp1, bp2;
  logic           free_hit, sel_hit, accept, load;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic [31:0]    sel_inst;
  logic [IDX_W:0] survivors;
  entry_t         new_ent;

  always_comb begin
    free_hit  = 1'b0;
    free_idx  = '0;
    sel_hit   = 1'b0;
    sel_idx   = '0;
    sel_inst  = '0;
    survivors = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    // strict compare while scanning upward keeps the lower index on a tie
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2 && (!sel_hit || ent_q[i].p.inst_num < sel_inst)) begin
        sel_hit  = 1'b1;
        sel_idx  = IDX_W'(i);
        sel_inst = ent_q[i].p.inst_num;
      end
      if (vld_q[i] && ent_q[i].p.inst_num <= rs.flush_inst_num)
        survivors = survivors + (IDX_W+1)'(1);
      wk1[i] = cdb_match(ent_q[i].tag1, rs.cdb_valid, rs.cdb_phy, rs.cdb_value, c1_valid, c1_phy, c1_value);
      wk2[i] = cdb_match(ent_q[i].tag2, rs.cdb_valid, rs.cdb_phy, rs.cdb_value, c1_valid, c1_phy, c1_value);
    end
    bp1 = cdb_match(rs.in_Operand1_phy, rs.cdb_valid, rs.cdb_phy, rs.cdb_value, c1_valid, c1_phy, c1_value);
    bp2 = cdb_match(rs.in_Operand2_phy, rs.cdb_valid, rs.cdb_phy, rs.cdb_value, c1_valid, c1_phy, c1_value);
    accept = rs.add_rs_on && !rs.rs_full && !rs.flush && free_hit;
    load   = !rs.flush && (!iss_vld_q || rs.issue_ready);

    new_ent             = '0;
    new_ent.p.operand1  = (rs.in_valid[0] || !bp1[32]) ? rs.in_operand1 : bp1[31:0];
    new_ent.p.operand2  = (rs.in_valid[1] || !bp2[32]) ? rs.in_operand2 : bp2[31:0];
    new_ent.p.rd        = rs.in_rd_phy_reg;
    new_ent.p.func3     = rs.in_func3;
    new_ent.p.pc        = rs.in_pc;
    new_ent.p.immediate = rs.in_immediate;
    new_ent.p.inst_num  = rs.in_inst_num;
    new_ent.p.ctrl      = rs.in_ctrl;
    new_ent.tag1        = rs.in_Operand1_phy;
    new_ent.tag2        = rs.in_Operand2_phy;
    new_ent.rdy1        = rs.in_valid[0] | bp1[32];
    new_ent.rdy2        = rs.in_valid[1] | bp2[32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && !ent_q[i].rdy1 && wk1[i][32]) begin
          ent_q[i].p.operand1 <= wk1[i][31:0];
          ent_q[i].rdy1       <= 1'b1;
        end
        if (vld_q[i] && !ent_q[i].rdy2 && wk2[i][32]) begin
          ent_q[i].p.operand2 <= wk2[i][31:0];
          ent_q[i].rdy2       <= 1'b1;
        end
        if (rs.flush && ent_q[i].p.inst_num > rs.flush_inst_num) vld_q[i] <= 1'b0;
      end
      if (load && sel_hit) vld_q[sel_idx] <= 1'b0;
      if (accept) begin
        vld_q[free_idx] <= 1'b1;
        ent_q[free_idx] <= new_ent;
      end

      if (rs.flush) begin
        if (iss_q.inst_num > rs.flush_inst_num) iss_vld_q <= 1'b0;
      end else if (load) begin
        iss_vld_q <= sel_hit;
        if (sel_hit) iss_q <= ent_q[sel_idx].p;
      end

      if (rs.flush) cnt_q <= survivors;
      else          cnt_q <= cnt_q + (IDX_W+1)'(accept) - (IDX_W+1)'(load && sel_hit);
    end
  end

  assign rs.rs_count         = cnt_q;
  assign rs.rs_full          = (cnt_q == (IDX_W+1)'(DEPTH));
  assign rs.issue_valid      = iss_vld_q;
  assign rs.issue_operand1   = iss_q.operand1;
  assign rs.issue_operand2   = iss_q.operand2;
  assign rs.issue_rd_phy_reg = iss_q.rd;
  assign rs.issue_func3      = iss_q.func3;
  assign rs.issue_pc         = iss_q.pc;
  assign rs.issue_immediate  = iss_q.immediate;
  assign rs.issue_inst_num   = iss_q.inst_num;
  assign rs.issue_ctrl       = iss_q.ctrl;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus random traffic checked against a
// queue-based model of the station's dispatch/wakeup/select/flush rules.
module tb_alu_reservation_station;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int PHY_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_reservation_station_if #(.PHY_W(PHY_W), .IDX_W(IDX_W)) bus ();
  alu_reservation_station #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PHY_W(PHY_W)) dut (
    .clk(clk), .reset(reset), .rs(bus.slave)
  );

  typedef struct {
    logic [31:0] op1, op2, inst, pc, imm;
    logic [PHY_W-1:0] t1, t2, rd;
    logic r1, r2;
    logic [2:0] f3;
    logic [8:0] ctrl;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_iss;
  bit m_iv = 0;
  int checks = 0;
  int failures = 0;
  logic [31:0] seq = 32'd100;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit mwake(input logic [PHY_W-1:0] tag, output logic [31:0] v);
    bit hit;
    hit = 0;
    v = '0;
    if (bus.cdb_valid && bus.cdb_phy == tag) begin hit = 1; v = bus.cdb_value; end
`ifdef RS_CDB_DUAL_EN
    if (bus.cdb1_valid && bus.cdb1_phy == tag) begin hit = 1; v = bus.cdb1_value; end
`endif
    return hit;
  endfunction

  task automatic model_edge();
    logic [31:0] v;
    int ci;
    int sz0;
    m_ent_t e;
    sz0 = mq.size();
    if (bus.flush) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].inst > bus.flush_inst_num) mq.delete(i);
      if (m_iv && m_iss.inst > bus.flush_inst_num) m_iv = 0;
    end else if (!m_iv || bus.issue_ready) begin
      ci = -1;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].r1 && mq[i].r2 && (ci < 0 || mq[i].inst < mq[ci].inst)) ci = i;
      m_iv = (ci >= 0);
      if (ci >= 0) begin m_iss = mq[ci]; mq.delete(ci); end
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].r1 && mwake(mq[i].t1, v)) begin mq[i].op1 = v; mq[i].r1 = 1; end
      if (!mq[i].r2 && mwake(mq[i].t2, v)) begin mq[i].op2 = v; mq[i].r2 = 1; end
    end
    if (!bus.flush && bus.add_rs_on && sz0 < DEPTH) begin
      e.inst = bus.in_inst_num; e.pc = bus.in_pc; e.imm = bus.in_immediate;
      e.t1 = bus.in_Operand1_phy; e.t2 = bus.in_Operand2_phy; e.rd = bus.in_rd_phy_reg;
      e.f3 = bus.in_func3; e.ctrl = bus.in_ctrl;
      e.op1 = bus.in_operand1; e.r1 = bus.in_valid[0];
      e.op2 = bus.in_operand2; e.r2 = bus.in_valid[1];
      if (!e.r1 && mwake(e.t1, v)) begin e.op1 = v; e.r1 = 1; end
      if (!e.r2 && mwake(e.t2, v)) begin e.op2 = v; e.r2 = 1; end
      mq.push_back(e);
    end
  endtask

  task automatic compare(input string tag);
    chk_val({tag, ".count"}, 32'(bus.rs_count), 32'(mq.size()));
    chk_val({tag, ".full"}, 32'(bus.rs_full), 32'(mq.size() == DEPTH));
    chk_val({tag, ".ivalid"}, 32'(bus.issue_valid), 32'(m_iv));
    if (m_iv && bus.issue_valid) begin
      chk_val({tag, ".op1"}, bus.issue_operand1, m_iss.op1);
      chk_val({tag, ".op2"}, bus.issue_operand2, m_iss.op2);
      chk_val({tag, ".inst"}, bus.issue_inst_num, m_iss.inst);
      chk_val({tag, ".pc"}, bus.issue_pc, m_iss.pc);
      chk_val({tag, ".imm"}, bus.issue_immediate, m_iss.imm);
      chk_val({tag, ".misc"}, 32'({bus.issue_rd_phy_reg, bus.issue_func3, bus.issue_ctrl}),
              32'({m_iss.rd, m_iss.f3, m_iss.ctrl}));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic idle();
    bus.add_rs_on = 0;
    bus.cdb_valid = 0;
    bus.flush = 0;
`ifdef RS_CDB_DUAL_EN
    bus.cdb1_valid = 0;
`endif
  endtask

  task automatic set_disp(input logic [31:0] inst, input logic [1:0] v, input logic [31:0] o1,
                          input logic [31:0] o2, input logic [PHY_W-1:0] t1, input logic [PHY_W-1:0] t2);
    bus.add_rs_on = 1;
    bus.in_inst_num = inst;
    bus.in_valid = v;
    bus.in_operand1 = o1;
    bus.in_operand2 = o2;
    bus.in_Operand1_phy = t1;
    bus.in_Operand2_phy = t2;
    bus.in_rd_phy_reg = inst[PHY_W-1:0];
    bus.in_func3 = inst[2:0];
    bus.in_pc = inst << 2;
    bus.in_immediate = ~inst;
    bus.in_ctrl = inst[8:0];
  endtask

  task automatic set_cdb(input logic [PHY_W-1:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1;
    bus.cdb_phy = tag;
    bus.cdb_value = val;
  endtask

  task automatic hit_reset();
    reset = 0;
    #1;
    mq.delete();
    m_iv = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.issue_ready = 1;
    bus.cdb_phy = '0;
    bus.cdb_value = '0;
    bus.flush_inst_num = '0;
    set_disp(0, 0, 0, 0, 0, 0);
    bus.add_rs_on = 0;
`ifdef RS_CDB_DUAL_EN
    bus.cdb1_phy = '0;
    bus.cdb1_value = '0;
`endif
    repeat (2) @(negedge clk);
    chk_val("rst.ivalid", 32'(bus.issue_valid), 0);
    chk_val("rst.count", 32'(bus.rs_count), 0);
    chk_val("rst.full", 32'(bus.rs_full), 0);
    chk_val("rst.op1", bus.issue_operand1, 0);
    chk_val("rst.inst", bus.issue_inst_num, 0);
    reset = 1;

    // T2: ready op issues one edge after dispatch
    set_disp(10, 2'b11, 5, 7, 0, 0);
    cycle("t2a");
    chk_val("t2.ivalid_early", 32'(bus.issue_valid), 0);
    idle();
    cycle("t2b");
    chk_val("t2.ivalid", 32'(bus.issue_valid), 1);
    chk_val("t2.op1", bus.issue_operand1, 5);
    chk_val("t2.op2", bus.issue_operand2, 7);
    cycle("t2c");

    // T3: younger ready op issues first, older one after wakeup
    set_disp(20, 2'b10, 0, 9, 8'h12, 0);
    cycle("t3a");
    set_disp(21, 2'b11, 1, 2, 0, 0);
    cycle("t3b");
    idle();
    set_cdb(8'h12, 32'hAB);
    cycle("t3c");
    chk_val("t3.first", bus.issue_inst_num, 21);
    idle();
    cycle("t3d");
    chk_val("t3.second", bus.issue_inst_num, 20);
    chk_val("t3.wake_op1", bus.issue_operand1, 32'hAB);
    cycle("t3e");

    // T4: fill, drop overflow dispatch, one wakeup + issue
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(32'(40 + i), 2'b10, 0, 32'(i), 8'(8'h40 + i), 0);
      cycle("t4fill");
    end
    chk_val("t4.full", 32'(bus.rs_full), 1);
    set_disp(48, 2'b11, 3, 3, 0, 0);
    cycle("t4ovf");
    chk_val("t4.ovf_count", 32'(bus.rs_count), 8);
    idle();
    set_cdb(8'h43, 32'h1234);
    cycle("t4wake");
    idle();
    cycle("t4issue");
    chk_val("t4.count7", 32'(bus.rs_count), 7);
    chk_val("t4.issued", bus.issue_inst_num, 43);
    hit_reset();
    @(negedge clk);
    reset = 1;

    // T5: flush kills younger entries and the held issue op
    bus.issue_ready = 0;
    for (int i = 30; i <= 35; i++) begin
      if (i == 34) set_disp(32'(i), 2'b11, 32'(i), 32'(i), 0, 0);
      else set_disp(32'(i), 2'b00, 0, 0, 8'(8'h60 + i), 8'(8'h80 + i));
      cycle("t5fill");
    end
    idle();
    cycle("t5hold");
    chk_val("t5.held", bus.issue_inst_num, 34);
    bus.flush = 1;
    bus.flush_inst_num = 32;
    cycle("t5flush");
    chk_val("t5.count", 32'(bus.rs_count), 3);
    chk_val("t5.ivalid", 32'(bus.issue_valid), 0);
    idle();

    // T1: async reset mid-run with 5 entries
    set_disp(36, 2'b00, 0, 0, 8'h70, 8'h71);
    cycle("t1a");
    set_disp(37, 2'b00, 0, 0, 8'h72, 8'h73);
    cycle("t1b");
    idle();
    chk_val("t1.pre_count", 32'(bus.rs_count), 5);
    @(posedge clk);
    model_edge();
    #2;
    hit_reset();
    chk_val("t1.ivalid", 32'(bus.issue_valid), 0);
    chk_val("t1.count", 32'(bus.rs_count), 0);
    chk_val("t1.full", 32'(bus.rs_full), 0);
    @(negedge clk);
    reset = 1;

    // T6: backpressure holds issue stable, then back-to-back in age order
    bus.issue_ready = 0;
    for (int i = 50; i <= 52; i++) begin
      set_disp(32'(i), 2'b11, 32'(i * 3), 32'(i * 5), 0, 0);
      cycle("t6fill");
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle("t6hold");
      chk_val("t6.stable", bus.issue_inst_num, 50);
    end
    bus.issue_ready = 1;
    cycle("t6r1");
    chk_val("t6.next", bus.issue_inst_num, 51);
    cycle("t6r2");
    chk_val("t6.last", bus.issue_inst_num, 52);
    cycle("t6r3");

    for (int c = 0; c < 2000; c++) begin
      bus.issue_ready = ($urandom_range(0, 9) < 7);
      bus.cdb_valid = 1'($urandom_range(0, 1));
      bus.cdb_phy = 8'($urandom_range(0, 15));
      bus.cdb_value = $urandom;
`ifdef RS_CDB_DUAL_EN
      bus.cdb1_valid = 1'($urandom_range(0, 1));
      bus.cdb1_phy = 8'($urandom_range(0, 15));
      bus.cdb1_value = $urandom;
`endif
      bus.flush = ($urandom_range(0, 29) == 0);
      bus.flush_inst_num = seq - 32'($urandom_range(1, 6));
      if ($urandom_range(0, 2) != 0) begin
        set_disp(seq, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
        seq = seq + 1;
      end else begin
        bus.add_rs_on = 0;
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
